// File: rtl/rr_grant_fsm.sv
// rr_grant_fsm: registered one-hot grant controller for the round-robin arbiter.
// Define RR_GRANT_TIMEOUT_EN to force release after MAX_HOLD grant cycles.
module rr_grant_fsm #(
  parameter int WIDTH    = 8,
  parameter int MAX_HOLD = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] req,
  input  logic [WIDTH-1:0] ptr,
  output logic [WIDTH-1:0] grant,
  output logic             busy,
  output logic             ptr_load,
  output logic [WIDTH-1:0] ptr_next,
  output logic             expired
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_e;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] grant_q, grant_d;
  logic [WIDTH-1:0] ptr_next_q, ptr_next_d;

  logic [WIDTH-1:0] ptr_lo;
  logic [WIDTH-1:0] ptr_sel;
  logic [WIDTH-1:0] hi_mask;
  logic [WIDTH-1:0] req_hi;
  logic [WIDTH-1:0] winner;
  logic             owner_req;

`ifdef RR_GRANT_TIMEOUT_EN
  localparam int CW = $clog2(MAX_HOLD + 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);

  logic [CW-1:0] hold_q, hold_d;
  logic          expired_q, expired_d;
`endif

  // Pick the first requester at or above the sanitised pointer, else wrap.
  always_comb begin
    ptr_lo  = ptr & (~ptr + ONE);
    ptr_sel = (ptr == '0) ? ONE : ptr_lo;
    hi_mask = ~(ptr_sel - ONE);
    req_hi  = req & hi_mask;
    if (req_hi != '0) begin
      winner = req_hi & (~req_hi + ONE);
    end else begin
      winner = req & (~req + ONE);
    end
    owner_req = |(req & grant_q);
  end

  // Next-state logic; the grant is only ever changed on state transitions.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    ptr_next_d = ptr_next_q;
`ifdef RR_GRANT_TIMEOUT_EN
    hold_d     = hold_q;
    expired_d  = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (req != '0) begin
          grant_d = winner;
          state_d = GRANT;
`ifdef RR_GRANT_TIMEOUT_EN
          hold_d  = '0;
`endif
        end
      end
      GRANT: begin
        if (!owner_req) begin
          grant_d    = '0;
          ptr_next_d = grant_q;
          state_d    = RELEASE;
`ifdef RR_GRANT_TIMEOUT_EN
        end else if (hold_q == HOLD_LAST) begin
          grant_d    = '0;
          ptr_next_d = grant_q;
          expired_d  = 1'b1;
          state_d    = RELEASE;
        end else begin
          hold_d = hold_q + 1'b1;
`endif
        end
      end
      RELEASE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  // State and output registers; reset clears everything at once.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      ptr_next_q <= '0;
`ifdef RR_GRANT_TIMEOUT_EN
      hold_q     <= '0;
      expired_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      ptr_next_q <= ptr_next_d;
`ifdef RR_GRANT_TIMEOUT_EN
      hold_q     <= hold_d;
      expired_q  <= expired_d;
`endif
    end
  end

  assign grant    = grant_q;
  assign busy     = (state_q == GRANT);
  assign ptr_load = (state_q == RELEASE);
  assign ptr_next = ptr_next_q;

`ifdef RR_GRANT_TIMEOUT_EN
  assign expired = expired_q;
`else
  // Grants never time out; MAX_HOLD >= 1 keeps this constant low.
  assign expired = (MAX_HOLD < 1);
`endif

endmodule
